seg7_reader: RTL and testbench
==============================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter STABLE_CNT, default 4, range 2..15: consecutive identical synchronized samples required before a digit is captured.
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Resetn  input  1  asynchronous, active-low reset.
REQ-004 SEG  input  [0:6]  active-low segment lines of a multiplexed display; SEG[0]=a ... SEG[6]=g.
REQ-005 DIG  input  [3:0]  active-low digit enables; DIG[i]=0 selects digit i.
REQ-006 VALUE  output  [15:0]  decoded hex digits; nibble i (VALUE[4i+3:4i]) belongs to digit i.
REQ-007 VALID  output  [3:0]  VALID[i]=1 when nibble i holds a decoded, non-blank pattern.
REQ-008 ERR  output  [3:0]  ERR[i]=1 when the last capture for digit i was unrecognized.
REQ-009 UPD  output  1  one-cycle pulse on every capture.

Function
REQ-010 SEG and DIG SHALL each pass through a two-flop synchronizer before any other use.
REQ-011 A synchronized sample is "single" when exactly one DIG bit is 0; all other DIG values are "idle".
REQ-012 FSM states: IDLE, TRACK, LOCKED; reset state IDLE.
REQ-013 IDLE -> TRACK on a single sample; stability counter loads 1 and the digit index and pattern are latched.
REQ-014 TRACK: same digit and same pattern as the latched ones -> counter +1; on reaching STABLE_CNT -> capture, go to LOCKED.
REQ-015 TRACK: same digit, different pattern -> relatch pattern, counter reloads 1, stay TRACK.
REQ-016 TRACK or LOCKED: different single digit -> relatch, counter 1, go TRACK; idle sample -> go IDLE, counter 0.
REQ-017 LOCKED: same digit and pattern -> hold, no further capture; same digit, new pattern -> TRACK with counter 1.
REQ-018 Capture decode table (SEG[0..6], 0=lit): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-019 Matching pattern -> nibble i := decoded value, VALID[i]=1, ERR[i]=0.
REQ-020 Blank pattern 1111111 -> VALID[i]=0, ERR[i]=0, nibble i unchanged.
REQ-021 Any other pattern -> ERR[i]=1, VALID[i]=0, nibble i unchanged.
REQ-022 Capture, VALUE/VALID/ERR update and the UPD pulse SHALL occur on the same edge; other digits are untouched.
REQ-023 Latency: inputs stable from edge n -> capture visible after edge n+1+STABLE_CNT (2 sync stages plus STABLE_CNT samples, first sample counted as 1).
REQ-024 Counter SHALL never exceed STABLE_CNT; no wrap-around.

Reset
REQ-025 Resetn=0 SHALL immediately clear synchronizers to idle (all ones), FSM to IDLE, counter to 0, VALUE=0, VALID=0, ERR=0, UPD=0.
REQ-026 Reset asserted mid-TRACK SHALL abandon the pending capture; no UPD after release until a full new stability window completes.

Configuration
REQ-027 Macro SEG7_READER_DP_EN defined: adds input DP (1, active-low decimal point, synchronized like SEG) and output DPO [3:0]; DP is part of the compared pattern; a capture of any kind sets DPO[i]=~DP; DPO resets to 0.
REQ-028 Macro undefined: no DP/DPO ports; behaviour exactly as REQ-010..026.

Verification
REQ-029 Reset, then DIG=1110, SEG=0010010 held 10 cycles, STABLE_CNT=4 -> VALUE[3:0]=2, VALID=0001, ERR=0000, single UPD pulse 6 edges after stimulus.
REQ-030 Scan DIG 1110/1101/1011/0111 with patterns 1,A,C,F, 8 cycles each -> VALUE=16'hFCA1, VALID=1111, exactly 4 UPD pulses.
REQ-031 DIG=1101, SEG toggling 0000001/1001111 every 3 cycles -> no UPD, VALUE unchanged.
REQ-032 DIG=1011 with SEG=1111110 -> ERR=0100, VALID[2]=0; then SEG=1111111 -> ERR=0000, VALID[2]=0, nibble 2 unchanged.
REQ-033 DIG=1100 (two active) or 1111 for 20 cycles -> FSM IDLE, no UPD.
REQ-034 Resetn pulsed low during TRACK counter=3 -> all outputs 0 at once; capture only after 2+STABLE_CNT further stable edges.

Source files
------------

// File: rtl/seg7_reader.sv
// ============================================================================
//  Module      : seg7_reader
//  Description : Recovers hex digits from a multiplexed active-low 7-segment
//                display bus. Optional decimal point via SEG7_READER_DP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_reader #(
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:6]  seg,
  input  logic [3:0]  dig,
`ifdef SEG7_READER_DP_EN
  input  logic        dp,
  output logic [3:0]  dpo,
`endif
  output logic [15:0] value,
  output logic [3:0]  valid,
  output logic [3:0]  err,
  output logic        upd
);

`ifdef SEG7_READER_DP_EN
  localparam int c_PW = 8;
`else
  localparam int c_PW = 7;
`endif
  localparam logic [3:0] c_STABLE = 4'(STABLE_CNT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [6:0]      r_seg_s1, r_seg_s2;
  logic [3:0]      r_dig_s1, r_dig_s2;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [1:0]      r_idx, w_idx_nxt, w_idx;
  logic [c_PW-1:0] r_pat, w_pat_nxt, w_sample;
  logic            w_single, w_capture;
  logic [6:0]      w_cap_seg;
  logic [3:0]      w_dec_val;
  logic            w_dec_hit, w_dec_blank;

`ifdef SEG7_READER_DP_EN
  logic r_dp_s1, r_dp_s2;
  assign w_sample = {r_seg_s2, r_dp_s2};
`else
  assign w_sample = r_seg_s2;
`endif
  // Segment field of the latched pattern; seg[0] (a) sits in the MSB.
  assign w_cap_seg = r_pat[c_PW-1 -: 7];

  always_comb begin
    w_single = 1'b1;
    w_idx    = 2'd0;
    case (r_dig_s2)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_single = 1'b0;
    endcase
  end

  always_comb begin
    w_dec_val   = 4'h0;
    w_dec_hit   = 1'b1;
    w_dec_blank = 1'b0;
    case (w_cap_seg)
      7'b0000001: w_dec_val = 4'h0;
      7'b1001111: w_dec_val = 4'h1;
      7'b0010010: w_dec_val = 4'h2;
      7'b0000110: w_dec_val = 4'h3;
      7'b1001100: w_dec_val = 4'h4;
      7'b0100100: w_dec_val = 4'h5;
      7'b0100000: w_dec_val = 4'h6;
      7'b0001111: w_dec_val = 4'h7;
      7'b0000000: w_dec_val = 4'h8;
      7'b0000100: w_dec_val = 4'h9;
      7'b0001000: w_dec_val = 4'hA;
      7'b1100000: w_dec_val = 4'hB;
      7'b0110001: w_dec_val = 4'hC;
      7'b1000010: w_dec_val = 4'hD;
      7'b0110000: w_dec_val = 4'hE;
      7'b0111000: w_dec_val = 4'hF;
      7'b1111111: begin w_dec_hit = 1'b0; w_dec_blank = 1'b1; end
      default:    w_dec_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_pat_nxt   = r_pat;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_single) begin
          w_state_nxt = ST_TRACK;
          w_cnt_nxt   = 4'd1;
          w_idx_nxt   = w_idx;
          w_pat_nxt   = w_sample;
        end
      end
      ST_TRACK, ST_LOCKED: begin
        if (!w_single) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (w_idx != r_idx || w_sample != r_pat) begin
          w_state_nxt = ST_TRACK;
          w_cnt_nxt   = 4'd1;
          w_idx_nxt   = w_idx;
          w_pat_nxt   = w_sample;
        end else if (r_state == ST_TRACK) begin
          // Capture fires on the edge where the count would reach the limit.
          if (r_cnt + 4'd1 == c_STABLE) begin
            w_state_nxt = ST_LOCKED;
            w_cnt_nxt   = c_STABLE;
            w_capture   = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_dig_s1 <= '1;
      r_dig_s2 <= '1;
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= 2'd0;
      r_pat    <= '1;
    end else begin
      r_seg_s1 <= seg;
      r_seg_s2 <= r_seg_s1;
      r_dig_s1 <= dig;
      r_dig_s2 <= r_dig_s1;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_pat    <= w_pat_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 16'h0000;
      valid <= 4'h0;
      err   <= 4'h0;
      upd   <= 1'b0;
    end else begin
      upd <= w_capture;
      if (w_capture) begin
        valid[r_idx] <= w_dec_hit;
        err[r_idx]   <= !w_dec_hit && !w_dec_blank;
        if (w_dec_hit) begin
          value[{r_idx, 2'b00} +: 4] <= w_dec_val;
        end
      end
    end
  end

`ifdef SEG7_READER_DP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_s1 <= 1'b1;
      r_dp_s2 <= 1'b1;
      dpo     <= 4'h0;
    end else begin
      r_dp_s1 <= dp;
      r_dp_s2 <= r_dp_s1;
      if (w_capture) begin
        dpo[r_idx] <= ~r_pat[0];
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg7_reader.sv
// ============================================================================
//  Module      : tb_seg7_reader
//  Description : Self-checking bench for seg7_reader (table, corner cases,
//                randomized traffic against a run-length reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_reader;

  localparam int STABLE_CNT = 4;

  logic        clk;
  logic        rst_n;
  logic [0:6]  seg;
  logic [3:0]  dig;
  logic [15:0] value;
  logic [3:0]  valid;
  logic [3:0]  err;
  logic        upd;
`ifdef SEG7_READER_DP_EN
  logic        dp;
  logic [3:0]  dpo;
`endif

  int checks = 0;
  int errors = 0;

  seg7_reader #(.STABLE_CNT(STABLE_CNT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seg   (seg),
    .dig   (dig),
`ifdef SEG7_READER_DP_EN
    .dp    (dp),
    .dpo   (dpo),
`endif
    .value (value),
    .valid (valid),
    .err   (err),
    .upd   (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0]  pat_tab [16];
  logic [10:0] m_pipe [2];      // {seg, dig} as seen by the two sync stages
  logic [10:0] m_last;
  int          m_run;
  logic [15:0] m_value;
  logic [3:0]  m_valid, m_err;
  logic        m_upd;

  task automatic model_reset();
    m_pipe[0] = '1;
    m_pipe[1] = '1;
    m_last    = '1;
    m_run     = 0;
    m_value   = 16'h0;
    m_valid   = 4'h0;
    m_err     = 4'h0;
    m_upd     = 1'b0;
  endtask

  // A capture happens when a single-digit sample has repeated exactly
  // STABLE_CNT times in a row.
  task automatic model_edge(input logic [6:0] s, input logic [3:0] d);
    logic [10:0] smp;
    int          di;
    int          hit;
    smp       = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = {s, d};
    m_upd     = 1'b0;
    di = -1;
    for (int i = 0; i < 4; i++) if (smp[3:0] == ~(4'b0001 << i)) di = i;
    if (di < 0) begin
      m_run = 0;
    end else begin
      m_run  = (m_run > 0 && smp == m_last) ? m_run + 1 : 1;
      m_last = smp;
      if (m_run == STABLE_CNT) begin
        m_upd = 1'b1;
        hit = -1;
        for (int k = 0; k < 16; k++) if (pat_tab[k] == smp[10:4]) hit = k;
        if (hit >= 0) begin
          m_value[di*4 +: 4] = 4'(hit);
          m_valid[di] = 1'b1;
          m_err[di]   = 1'b0;
        end else begin
          m_valid[di] = 1'b0;
          m_err[di]   = (smp[10:4] != 7'b1111111);
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [6:0] s, input logic [3:0] d);
    seg = s;
    dig = d;
    @(posedge clk);
    model_edge(s, d);
    #1;
    check("cycle_vs_model", {7'd0, value, valid, err, upd},
          {7'd0, m_value, m_valid, m_err, m_upd});
  endtask

  typedef struct {
    logic [6:0]  s;
    logic [3:0]  d;
    int          hold;
    logic [15:0] value;
    logic [3:0]  valid;
    logic [3:0]  err;
    int          upds;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int n_upd;
    int first;
    logic [6:0] s;
    logic [3:0] d;

    pat_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    tbl[0]  = '{7'b1001111, 4'b1110, 8,  16'h0001, 4'b0001, 4'b0000, 1};
    tbl[1]  = '{7'b0001000, 4'b1101, 8,  16'h00A1, 4'b0011, 4'b0000, 1};
    tbl[2]  = '{7'b0110001, 4'b1011, 8,  16'h0CA1, 4'b0111, 4'b0000, 1};
    tbl[3]  = '{7'b0111000, 4'b0111, 8,  16'hFCA1, 4'b1111, 4'b0000, 1};
    tbl[4]  = '{7'b0000001, 4'b1101, 3,  16'hFCA1, 4'b1111, 4'b0000, 0};
    tbl[5]  = '{7'b1001111, 4'b1101, 3,  16'hFCA1, 4'b1111, 4'b0000, 0};
    tbl[6]  = '{7'b0000001, 4'b1101, 3,  16'hFCA1, 4'b1111, 4'b0000, 0};
    tbl[7]  = '{7'b1001111, 4'b1101, 3,  16'hFCA1, 4'b1111, 4'b0000, 0};
    tbl[8]  = '{7'b1111110, 4'b1011, 8,  16'hFCA1, 4'b1011, 4'b0100, 1};
    tbl[9]  = '{7'b1111111, 4'b1011, 8,  16'hFCA1, 4'b1011, 4'b0000, 1};
    tbl[10] = '{7'b0000110, 4'b1100, 20, 16'hFCA1, 4'b1011, 4'b0000, 0};
    tbl[11] = '{7'b0000110, 4'b1111, 20, 16'hFCA1, 4'b1011, 4'b0000, 0};

`ifdef SEG7_READER_DP_EN
    dp = 1'b1;
`endif
    seg   = 7'b1111111;
    dig   = 4'b1111;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_outputs", {7'd0, value, valid, err, upd}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", {7'd0, value, valid, err, upd}, 32'd0);
    rst_n = 1'b1;

    // Single digit '2' on digit 0: measure latency and pulse count.
    n_upd = 0;
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      step(7'b0010010, 4'b1110);
      if (upd) begin
        n_upd++;
        if (first < 0) first = k;
      end
    end
    check("latency_edges", first, 2 + STABLE_CNT);
    check("single_upd_count", n_upd, 1);
    check("digit2_outputs", {7'd0, value, valid, err, upd}, {7'd0, 16'h0002, 4'b0001, 4'b0000, 1'b0});

    for (int t = 0; t < 12; t++) begin
      n_upd = 0;
      for (int k = 0; k < tbl[t].hold; k++) begin
        step(tbl[t].s, tbl[t].d);
        if (upd) n_upd++;
      end
      check($sformatf("tbl%0d_outputs", t), {8'd0, value, valid, err},
            {8'd0, tbl[t].value, tbl[t].valid, tbl[t].err});
      check($sformatf("tbl%0d_upds", t), n_upd, tbl[t].upds);
    end

    // Reset in the middle of a stability window (counter at 3).
    for (int k = 0; k < 2 + 3; k++) step(7'b0100100, 4'b1110);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midtrack_reset_clear", {7'd0, value, valid, err, upd}, 32'd0);
    #1 rst_n = 1'b1;
    first = -1;
    n_upd = 0;
    for (int k = 1; k <= 20; k++) begin
      step(7'b0100100, 4'b1110);
      if (upd) begin
        n_upd++;
        if (first < 0) first = k;
      end
    end
    check("post_reset_latency", first, 2 + STABLE_CNT);
    check("post_reset_upds", n_upd, 1);
    check("post_reset_value", {12'd0, value, valid}, {12'd0, 16'h0005, 4'b0001});

    // Randomized traffic, every cycle compared against the model.
    for (int b = 0; b < 300; b++) begin
      case ($urandom_range(0, 6))
        0: d = 4'b1110;
        1: d = 4'b1101;
        2: d = 4'b1011;
        3: d = 4'b0111;
        4: d = 4'b1111;
        default: d = 4'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: s = 7'b1111111;
        1: s = 7'($urandom);
        default: s = pat_tab[$urandom_range(0, 15)];
      endcase
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) step(s, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
